// File: rtl/sdram_port_arbiter_if.sv
// Bundle between the three SDRAM requesters, the arbiter and the SDRAM controller.
// Requester side: req/we/addr/din/be in, ack/err/dout back (port n at slice n).
// Controller side: mem_req/mem_we/mem_addr/mem_din/mem_be out, mem_ack/mem_dout back.
// Status: busy (transaction in flight), grant_id (port being served, 3 = none).
// Modport slave is the arbiter's view; modport master is the environment's view.
interface sdram_port_arbiter_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 16
);
  // requester side
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] din;
  logic [5:0]      be;
  logic [2:0]      ack;
  logic [2:0]      err;
  logic [DW-1:0]   dout;

  // controller side
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [1:0]      mem_be;
  logic            mem_ack;
  logic [DW-1:0]   mem_dout;

  // status
  logic            busy;
  logic [1:0]      grant_id;

  modport slave (
    input  req, we, addr, din, be, mem_ack, mem_dout,
    output ack, err, dout, mem_req, mem_we, mem_addr, mem_din, mem_be, busy, grant_id
  );

  modport master (
    output req, we, addr, din, be, mem_ack, mem_dout,
    input  ack, err, dout, mem_req, mem_we, mem_addr, mem_din, mem_be, busy, grant_id
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM controller command port between three requesters:
// port 0 (CPU/ANTIC, priority), port 1 (data_io upload), port 2 (OSD).
// Port 0 has fixed priority bounded by a starvation guard, ports 1 and 2 are
// served round-robin, and each transaction is aborted after TIMEOUT wait cycles.
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - requester and controller bundle (slave modport), all outputs registered
module sdram_port_arbiter #(
  parameter int unsigned AW           = 24,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  sdram_port_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          rr_sel;      // 0: port 1 next, 1: port 2 next
  logic [TW-1:0] tmo_cnt;

  logic          others_pend_c;
  logic          p0_wins_c;
  logic [1:0]    win_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_din_c;
  logic [1:0]    sel_be_c;
  logic [2:0]    gnt_onehot_c;

  // Winner selection and field mux for the requester about to be latched
  always_comb begin
    others_pend_c = bus.req[1] | bus.req[2];
    // port 0 yields only once it has starved the others STARVE_LIMIT times
    p0_wins_c     = bus.req[0] && !((starve_cnt == SW'(STARVE_LIMIT)) && others_pend_c);
    win_c         = 2'd2;
    if (p0_wins_c) begin
      win_c = 2'd0;
    end else if (bus.req[1] && bus.req[2]) begin
      win_c = rr_sel ? 2'd2 : 2'd1;
    end else if (bus.req[1]) begin
      win_c = 2'd1;
    end
    sel_we_c     = bus.we[win_c];
    sel_addr_c   = bus.addr[32'(win_c) * AW +: AW];
    sel_din_c    = bus.din[32'(win_c) * DW +: DW];
    sel_be_c     = bus.be[32'(win_c) * 2 +: 2];
    // grant_id of 3 decodes to no port
    gnt_onehot_c = 3'b001 << bus.grant_id;
  end

  // Arbitration FSM with registered outputs; ack/err default low so they pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      rr_sel       <= 1'b0;
      tmo_cnt      <= '0;
      bus.ack      <= '0;
      bus.err      <= '0;
      bus.dout     <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.mem_be   <= '0;
      bus.busy     <= 1'b0;
      bus.grant_id <= 2'd3;
    end else begin
      bus.ack <= '0;
      bus.err <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.mem_we   <= sel_we_c;
            bus.mem_addr <= sel_addr_c;
            bus.mem_din  <= sel_din_c;
            bus.mem_be   <= sel_be_c;
            bus.grant_id <= win_c;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
            if (win_c == 2'd0) begin
              if (!others_pend_c) begin
                starve_cnt <= '0;
              end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
              end
            end else begin
              starve_cnt <= '0;
              rr_sel     <= ~rr_sel;
            end
          end
        end

        ISSUE: begin
          bus.mem_req <= 1'b1;
          tmo_cnt     <= '0;
          state       <= WAIT;
        end

        WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.dout    <= bus.mem_dout;
            bus.ack     <= gnt_onehot_c;
            state       <= DONE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            // this WAIT cycle is the TIMEOUT-th without an answer
            bus.mem_req <= 1'b0;
            bus.ack     <= gnt_onehot_c;
            bus.err     <= gnt_onehot_c;
            tmo_cnt     <= tmo_cnt + TW'(1);
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        DONE: begin
          bus.busy     <= 1'b0;
          bus.grant_id <= 2'd3;
          tmo_cnt      <= '0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus pushes expected controller
// issues and requester responses into queues, a monitor pops and compares them.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sdram_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(8), .TIMEOUT(255)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]    port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    be;
    int            len;   // expected mem_req high cycles, 0 = not checked
  } issue_t;

  typedef struct {
    logic [1:0]    port;
    logic [2:0]    ack;
    logic [2:0]    err;
    logic [DW-1:0] dout;
  } resp_t;

  issue_t exp_issue[$];
  resp_t  exp_resp[$];

  int checks    = 0;
  int errors    = 0;
  int ack_count = 0;

  logic [AW-1:0] p_addr [3];
  logic [DW-1:0] p_din  [3];
  logic          p_we   [3];
  logic [1:0]    p_be   [3];
  logic [DW-1:0] model_dout = '0;

  // memory model controls
  int            ack_delay = 2;
  bit            mem_en    = 1'b1;
  bit            force_ack = 1'b0;
  logic [DW-1:0] key       = 16'hA5A5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < 3; i++) begin
      bus.we[i]               = p_we[i];
      bus.addr[i*AW +: AW]    = p_addr[i];
      bus.din[i*DW +: DW]     = p_din[i];
      bus.be[i*2 +: 2]        = p_be[i];
    end
  endtask

  task automatic expect_txn(input int p, input int len, input bit tmo, input bit want_ack);
    issue_t it;
    resp_t  r;
    it.port = 2'(p);
    it.we   = p_we[p];
    it.addr = p_addr[p];
    it.din  = p_din[p];
    it.be   = p_be[p];
    it.len  = len;
    exp_issue.push_back(it);
    if (want_ack) begin
      r.port = 2'(p);
      r.ack  = 3'(3'b001 << p);
      r.err  = tmo ? r.ack : 3'b000;
      r.dout = tmo ? model_dout : (p_addr[p][DW-1:0] ^ key);
      model_dout = r.dout;
      exp_resp.push_back(r);
    end
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_count < target && n < budget) begin
      tick();
      n++;
    end
    if (ack_count < target) fail_now("ack_wait", "no ack within cycle budget");
  endtask

  // SDRAM controller model: acks ack_delay cycles into mem_req, data = addr ^ key
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
    forever begin
      @(negedge clk_sys);
      if (force_ack) begin
        bus.mem_ack  = 1'b1;
        bus.mem_dout = 16'hDEAD;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wcnt        = 0;
      end else if (bus.mem_req && mem_en) begin
        wcnt++;
        if (wcnt == ack_delay) begin
          bus.mem_ack  = 1'b1;
          bus.mem_dout = bus.mem_addr[DW-1:0] ^ key;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares issues, field stability, request length and responses
  initial begin
    logic   prev_req;
    int     req_len;
    issue_t cur;
    resp_t  r;
    prev_req = 1'b0;
    req_len  = 0;
    cur      = '{port: 2'd0, we: 1'b0, addr: '0, din: '0, be: 2'b00, len: 0};
    forever begin
      @(negedge clk_sys);
      if (bus.mem_req && !prev_req) begin
        req_len = 1;
        if (exp_issue.size() == 0) begin
          fail_now("issue_unexpected", "mem_req rose with nothing expected");
        end else begin
          cur = exp_issue.pop_front();
          check("issue_grant", 32'(bus.grant_id), 32'(cur.port));
          check("issue_busy",  32'(bus.busy),     32'd1);
          check("issue_we",    32'(bus.mem_we),   32'(cur.we));
          check("issue_addr",  32'(bus.mem_addr), 32'(cur.addr));
          check("issue_din",   32'(bus.mem_din),  32'(cur.din));
          check("issue_be",    32'(bus.mem_be),   32'(cur.be));
        end
      end else if (bus.mem_req) begin
        req_len++;
        check("hold_addr", 32'(bus.mem_addr), 32'(cur.addr));
        check("hold_din",  32'(bus.mem_din),  32'(cur.din));
        check("hold_we",   32'(bus.mem_we),   32'(cur.we));
        check("hold_be",   32'(bus.mem_be),   32'(cur.be));
      end else if (prev_req && cur.len != 0) begin
        check("req_len", 32'(req_len), 32'(cur.len));
      end

      if (bus.ack != 3'b000) begin
        ack_count++;
        if (exp_resp.size() == 0) begin
          fail_now("ack_unexpected", $sformatf("ack=%b with nothing expected", bus.ack));
        end else begin
          r = exp_resp.pop_front();
          check("resp_ack",   32'(bus.ack),      32'(r.ack));
          check("resp_err",   32'(bus.err),      32'(r.err));
          check("resp_dout",  32'(bus.dout),     32'(r.dout));
          check("resp_grant", 32'(bus.grant_id), 32'(r.port));
          check("resp_busy",  32'(bus.busy),     32'd1);
          // ack lands in the cycle right after the last mem_req cycle
          check("resp_timing", 32'(prev_req && !bus.mem_req), 32'd1);
        end
      end else begin
        check("err_without_ack", 32'(bus.err), 32'd0);
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset_n  = 1'b0;
    bus.req  = '0;
    p_addr   = '{24'h000100, 24'h000200, 24'h000300};
    p_din    = '{16'h1111, 16'h2222, 16'h3333};
    p_we     = '{1'b0, 1'b0, 1'b0};
    p_be     = '{2'b11, 2'b10, 2'b00};
    drive_fields();
    repeat (2) tick();

    // reset values
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_grant",    32'(bus.grant_id), 32'd3);
    check("rst_ack",      32'(bus.ack),      32'd0);
    check("rst_dout",     32'(bus.dout),     32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // starvation guard: all three held, port 0 continuous
    key       = 16'hA5A5;
    ack_delay = 2;
    for (int k = 0; k < 8; k++) expect_txn(0, 2, 1'b0, 1'b1);
    expect_txn(1, 2, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) expect_txn(0, 2, 1'b0, 1'b1);
    expect_txn(2, 2, 1'b0, 1'b1);
    base    = ack_count;
    bus.req = 3'b111;
    wait_acks(base + 18, 400);
    bus.req = 3'b000;
    repeat (2) tick();

    // round-robin between ports 1 and 2
    expect_txn(1, 2, 1'b0, 1'b1);
    expect_txn(2, 2, 1'b0, 1'b1);
    expect_txn(1, 2, 1'b0, 1'b1);
    expect_txn(2, 2, 1'b0, 1'b1);
    base    = ack_count;
    bus.req = 3'b110;
    wait_acks(base + 4, 100);
    bus.req = 3'b000;
    repeat (2) tick();

    // single read on port 1 with exact latency
    key       = 16'hACDB;          // 0x1234 ^ 0xACDB = 0xBEEF
    ack_delay = 3;
    p_addr[1] = 24'h001234;
    drive_fields();
    expect_txn(1, 3, 1'b0, 1'b1);
    base    = ack_count;
    bus.req = 3'b010;
    tick();
    check("lat_issue_mem_req", 32'(bus.mem_req),  32'd0);
    check("lat_issue_busy",    32'(bus.busy),     32'd1);
    check("lat_issue_addr",    32'(bus.mem_addr), 32'h001234);
    tick();
    check("lat_mem_req_n2",    32'(bus.mem_req),  32'd1);
    wait_acks(base + 1, 20);
    check("read_dout", 32'(bus.dout), 32'h0000BEEF);
    check("read_ack",  32'(bus.ack),  32'b010);
    bus.req = 3'b000;
    tick();
    check("read_grant_idle", 32'(bus.grant_id), 32'd3);
    check("read_busy_idle",  32'(bus.busy),     32'd0);
    repeat (2) tick();

    // write on port 0; requester fields change mid-flight
    ack_delay = 4;
    p_we[0]   = 1'b1;
    p_din[0]  = 16'h55AA;
    p_be[0]   = 2'b01;
    drive_fields();
    expect_txn(0, 4, 1'b0, 1'b1);
    base    = ack_count;
    bus.req = 3'b001;
    repeat (2) tick();
    p_addr[0] = 24'hFFFFFF;
    p_din[0]  = 16'h0000;
    p_be[0]   = 2'b10;
    p_we[0]   = 1'b0;
    drive_fields();
    wait_acks(base + 1, 20);
    bus.req = 3'b000;
    repeat (4) tick();
    check("write_single_ack", 32'(ack_count - base), 32'd1);
    p_addr[0] = 24'h000100;
    p_din[0]  = 16'h1111;
    p_be[0]   = 2'b11;
    drive_fields();

    // timeout on port 2
    mem_en = 1'b0;
    expect_txn(2, 255, 1'b1, 1'b1);
    base    = ack_count;
    bus.req = 3'b100;
    wait_acks(base + 1, 300);
    bus.req = 3'b000;
    mem_en  = 1'b1;
    repeat (2) tick();

    // reset during WAIT, stray ack afterwards
    mem_en = 1'b0;
    expect_txn(1, 0, 1'b0, 1'b0);
    base    = ack_count;
    bus.req = 3'b010;
    repeat (4) tick();
    check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async_mem_req", 32'(bus.mem_req),  32'd0);
    check("rst_async_busy",    32'(bus.busy),     32'd0);
    check("rst_async_grant",   32'(bus.grant_id), 32'd3);
    bus.req = 3'b000;
    repeat (2) tick();
    reset_n    = 1'b1;
    model_dout = '0;
    mem_en     = 1'b1;
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    repeat (3) tick();
    check("stray_no_ack",   32'(ack_count - base), 32'd0);
    check("stray_busy",     32'(bus.busy),         32'd0);
    check("stray_mem_req",  32'(bus.mem_req),      32'd0);
    check("stray_dout",     32'(bus.dout),         32'd0);

    // normal service after reset; rr pointer back at port 1
    ack_delay = 2;
    expect_txn(1, 2, 1'b0, 1'b1);
    expect_txn(2, 2, 1'b0, 1'b1);
    base    = ack_count;
    bus.req = 3'b110;
    wait_acks(base + 2, 60);
    bus.req = 3'b000;
    repeat (4) tick();

    check("issue_queue_empty", 32'(exp_issue.size()), 32'd0);
    check("resp_queue_empty",  32'(exp_resp.size()),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
